// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states, error codes
// and the framed byte-stream layout (LEN_HI, LEN_LO, N*4 big-endian payload bytes, XOR checksum).
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } boot_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Payload bytes arrive MSB first, so the fourth byte of a word is the least significant.
  localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

  function automatic logic isReceiving(input boot_state_e s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CSUM);
  endfunction

  function automatic logic isTimed(input boot_state_e s);
    return (s == S_LEN_LO) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs payload bytes into big-endian 32-bit words and keeps the running XOR checksum.
// o_wordValid is combinational: it marks the cycle in which the fourth byte is loaded.
module imem_boot_loader_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_wordValid,
  output logic [7:0]  o_csum
);

  logic [23:0] r_shift;
  logic [1:0]  r_byteCnt;
  logic [7:0]  r_csum;

  assign o_word      = {r_shift, i_byte};
  assign o_wordValid = i_load & (r_byteCnt == LAST_BYTE_IDX);
  assign o_csum      = r_csum;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift   <= 24'd0;
      r_byteCnt <= 2'd0;
      r_csum    <= 8'd0;
    end else if (i_clear) begin
      r_shift   <= 24'd0;
      r_byteCnt <= 2'd0;
      r_csum    <= 8'd0;
    end else if (i_load) begin
      r_shift   <= {r_shift[15:0], i_byte};
      r_byteCnt <= r_byteCnt + 2'd1;
      r_csum    <= r_csum ^ i_byte;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed byte stream into instruction memory and holds the MIPS core in reset
// until a frame with a valid checksum has been written.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int          ADDR_W         = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  input  logic        i_restart,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_core_reset,
  output logic        o_done,
  output logic [1:0]  o_err_code
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  boot_state_e r_state;
  boot_state_e w_stateNext;
  logic [1:0]  r_err;
  logic [1:0]  w_errNext;

  logic [7:0]      r_lenHi;
  logic [15:0]     r_len;
  logic [ADDR_W:0] r_wordIdx;
  logic [31:0]     r_idle;
  logic            r_imemWe;
  logic [31:0]     r_imemAddr;
  logic [31:0]     r_imemWdata;

  logic        w_accept;
  logic [15:0] w_lenFull;
  logic        w_lenTooBig;
  logic        w_lastWord;
  logic        w_timeout;
  logic        w_asmLoad;
  logic [31:0] w_word;
  logic        w_wordValid;
  logic [7:0]  w_csum;

  assign o_rx_ready = isReceiving(r_state) & ~i_restart;
  assign w_accept   = i_rx_valid & o_rx_ready;
  assign w_lenFull  = {r_lenHi, i_rx_data};
  assign w_lenTooBig = {1'b0, w_lenFull} > MAX_WORDS;
  // word_idx carries one extra bit so a frame of exactly 2**ADDR_W words is representable.
  assign w_lastWord = (17'(r_wordIdx) + 17'd1) == {1'b0, r_len};
  assign w_timeout  = (TIMEOUT_CYCLES != 32'd0) && isTimed(r_state) && !w_accept &&
                      ((r_idle + 32'd1) == TIMEOUT_CYCLES);
  assign w_asmLoad  = w_accept && (r_state == S_DATA);

  imem_boot_loader_word_assembler u_asm (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (i_restart),
    .i_load      (w_asmLoad),
    .i_byte      (i_rx_data),
    .o_word      (w_word),
    .o_wordValid (w_wordValid),
    .o_csum      (w_csum)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_LEN_HI;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_stateNext;
      r_err   <= w_errNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_errNext   = r_err;
    if (i_restart) begin
      w_stateNext = S_LEN_HI;
      w_errNext   = ERR_NONE;
    end else begin
      case (r_state)
        S_LEN_HI: begin
          if (w_accept) w_stateNext = S_LEN_LO;
        end
        S_LEN_LO: begin
          if (w_accept) begin
            if (w_lenTooBig) begin
              w_stateNext = S_ERR;
              w_errNext   = ERR_LEN;
            end else if (w_lenFull == 16'd0) begin
              w_stateNext = S_CSUM;
            end else begin
              w_stateNext = S_DATA;
            end
          end else if (w_timeout) begin
            w_stateNext = S_ERR;
            w_errNext   = ERR_TIMEOUT;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            if (w_wordValid && w_lastWord) w_stateNext = S_CSUM;
          end else if (w_timeout) begin
            w_stateNext = S_ERR;
            w_errNext   = ERR_TIMEOUT;
          end
        end
        S_CSUM: begin
          if (w_accept) begin
            if (i_rx_data == w_csum) begin
              w_stateNext = S_DONE;
            end else begin
              w_stateNext = S_ERR;
              w_errNext   = ERR_CSUM;
            end
          end else if (w_timeout) begin
            w_stateNext = S_ERR;
            w_errNext   = ERR_TIMEOUT;
          end
        end
        default: begin
          w_stateNext = r_state;
        end
      endcase
    end
  end

  // The write strobe is a registered one-cycle pulse following the edge that took byte four.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lenHi     <= 8'd0;
      r_len       <= 16'd0;
      r_wordIdx   <= '0;
      r_idle      <= 32'd0;
      r_imemWe    <= 1'b0;
      r_imemAddr  <= BASE_ADDR;
      r_imemWdata <= 32'd0;
    end else begin
      r_imemWe <= 1'b0;
      if (i_restart) begin
        r_lenHi   <= 8'd0;
        r_len     <= 16'd0;
        r_wordIdx <= '0;
        r_idle    <= 32'd0;
      end else begin
        if (w_accept || !isTimed(r_state)) r_idle <= 32'd0;
        else                               r_idle <= r_idle + 32'd1;
        if (w_accept && (r_state == S_LEN_HI)) r_lenHi <= i_rx_data;
        if (w_accept && (r_state == S_LEN_LO)) r_len   <= w_lenFull;
        if (w_wordValid) begin
          r_imemWe    <= 1'b1;
          r_imemWdata <= w_word;
          r_imemAddr  <= BASE_ADDR + (32'(r_wordIdx) << 2);
          r_wordIdx   <= r_wordIdx + 1'b1;
        end
      end
    end
  end

  assign o_imem_we    = r_imemWe;
  assign o_imem_addr  = r_imemAddr;
  assign o_imem_wdata = r_imemWdata;
  assign o_core_reset = (r_state != S_DONE);
  assign o_done       = (r_state == S_DONE);
  assign o_err_code   = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader: good/bad frames, length overflow,
// timeout, async reset mid-word, restart, and a full 2**ADDR_W-word frame.
module tb_imem_boot_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic        restart;
  logic        imemWe;
  logic [31:0] imemAddr;
  logic [31:0] imemWdata;
  logic        coreReset;
  logic        done;
  logic [1:0]  errCode;

  int checks   = 0;
  int failures = 0;

  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  logic [7:0]  txQ[$];

  imem_boot_loader #(
    .ADDR_W         (8),
    .BASE_ADDR      (32'h0),
    .TIMEOUT_CYCLES (32'd16)
  ) dut (
    .i_clk        (clock),
    .i_reset      (reset),
    .i_rx_data    (rxData),
    .i_rx_valid   (rxValid),
    .o_rx_ready   (rxReady),
    .i_restart    (restart),
    .o_imem_we    (imemWe),
    .o_imem_addr  (imemAddr),
    .o_imem_wdata (imemWdata),
    .o_core_reset (coreReset),
    .o_done       (done),
    .o_err_code   (errCode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every cycle the strobe is high at the falling edge counts as one IMEM write.
  always @(negedge clock) begin
    if (!reset && imemWe) begin
      wrAddr.push_back(imemAddr);
      wrData.push_back(imemWdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Presents one byte after an idle gap and waits (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    logic rdy;
    logic accepted;
    rxValid = 1'b0;
    if (gap > 0) tick(gap);
    rxData   = b;
    rxValid  = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clock);
      rdy = rxReady;
      @(posedge clock);
      #1;
      if (rdy) accepted = 1'b1;
    end
    rxValid = 1'b0;
    checkOutput("handshake", 32'(accepted), 32'd1);
  endtask

  task automatic sendFrame(input int maxGap);
    for (int i = 0; i < txQ.size(); i++)
      applyStimulus(txQ[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
  endtask

  task automatic loadFrame1(input logic [7:0] csum);
    txQ = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
    txQ.push_back(csum);
  endtask

  task automatic checkFrame1Writes(input string tag);
    @(negedge clock);
    checkOutput({tag, "_wrcnt"}, 32'(wrAddr.size()), 32'd2);
    if (wrAddr.size() == 2) begin
      checkOutput({tag, "_addr0"}, wrAddr[0], 32'h0000_0000);
      checkOutput({tag, "_data0"}, wrData[0], 32'h2008_0005);
      checkOutput({tag, "_addr1"}, wrAddr[1], 32'h0000_0004);
      checkOutput({tag, "_data1"}, wrData[1], 32'h2009_000A);
    end
  endtask

  task automatic pulseRestart(input logic withByte);
    restart = 1'b1;
    rxValid = withByte;
    rxData  = 8'hAA;
    @(negedge clock);
    checkOutput("restart_rdy", 32'(rxReady), 32'd0);
    @(posedge clock);
    #1;
    restart = 1'b0;
    rxValid = 1'b0;
    wrAddr.delete();
    wrData.delete();
  endtask

  initial begin
    reset   = 1'b1;
    rxData  = 8'h00;
    rxValid = 1'b0;
    restart = 1'b0;
    #12;
    checkOutput("rst_we",    32'(imemWe),    32'd0);
    checkOutput("rst_addr",  imemAddr,       32'h0);
    checkOutput("rst_wdata", imemWdata,      32'h0);
    checkOutput("rst_core",  32'(coreReset), 32'd1);
    checkOutput("rst_done",  32'(done),      32'd0);
    checkOutput("rst_err",   32'(errCode),   32'd0);
    checkOutput("rst_rdy",   32'(rxReady),   32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] test 1: good two-word frame");
    loadFrame1(8'h0E);
    sendFrame(0);
    checkFrame1Writes("t1");
    checkOutput("t1_done", 32'(done),      32'd1);
    checkOutput("t1_core", 32'(coreReset), 32'd0);
    checkOutput("t1_err",  32'(errCode),   32'd0);
    checkOutput("t1_rdy",  32'(rxReady),   32'd0);

    $display("[TB] test 6: restart in done with a byte present");
    pulseRestart(1'b1);
    @(negedge clock);
    checkOutput("t6_core", 32'(coreReset), 32'd1);
    checkOutput("t6_done", 32'(done),      32'd0);
    txQ = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tick(1);
    sendFrame(0);
    @(negedge clock);
    checkOutput("t6_wrcnt", 32'(wrAddr.size()), 32'd1);
    if (wrAddr.size() == 1) begin
      checkOutput("t6_addr", wrAddr[0], 32'h0);
      checkOutput("t6_data", wrData[0], 32'h0);
    end
    checkOutput("t6_done", 32'(done),    32'd1);
    checkOutput("t6_err",  32'(errCode), 32'd0);

    $display("[TB] test 2: bad checksum");
    pulseRestart(1'b0);
    loadFrame1(8'h0F);
    sendFrame(0);
    checkFrame1Writes("t2");
    checkOutput("t2_err",  32'(errCode),   32'd2);
    checkOutput("t2_done", 32'(done),      32'd0);
    checkOutput("t2_core", 32'(coreReset), 32'd1);

    $display("[TB] test 3: length overflow");
    pulseRestart(1'b0);
    txQ = '{8'h01, 8'h01};
    sendFrame(0);
    @(negedge clock);
    checkOutput("t3_err",   32'(errCode),        32'd1);
    checkOutput("t3_rdy",   32'(rxReady),        32'd0);
    checkOutput("t3_wrcnt", 32'(wrAddr.size()),  32'd0);

    $display("[TB] test 3b: maximum legal length 256 words");
    pulseRestart(1'b0);
    txQ = '{8'h01, 8'h00};
    for (int w = 0; w < 256; w++)
      for (int k = 0; k < 4; k++) txQ.push_back(8'(w));
    txQ.push_back(8'h00);
    sendFrame(0);
    @(negedge clock);
    checkOutput("t3b_wrcnt", 32'(wrAddr.size()), 32'd256);
    if (wrAddr.size() == 256) begin
      checkOutput("t3b_addr100", wrAddr[100], 32'h0000_0190);
      checkOutput("t3b_data100", wrData[100], 32'h6464_6464);
      checkOutput("t3b_addr255", wrAddr[255], 32'h0000_03FC);
      checkOutput("t3b_data255", wrData[255], 32'hFFFF_FFFF);
    end
    checkOutput("t3b_done", 32'(done),    32'd1);
    checkOutput("t3b_err",  32'(errCode), 32'd0);

    $display("[TB] test 4: random gaps, then timeout");
    pulseRestart(1'b0);
    loadFrame1(8'h0E);
    sendFrame(5);
    checkFrame1Writes("t4");
    checkOutput("t4_done", 32'(done),    32'd1);
    checkOutput("t4_err",  32'(errCode), 32'd0);

    pulseRestart(1'b0);
    tick(20);
    checkOutput("t4_lenhi_noto", 32'(errCode), 32'd0);
    checkOutput("t4_lenhi_rdy",  32'(rxReady), 32'd1);
    txQ = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09};
    sendFrame(0);
    tick(10);
    checkOutput("t4_gap10_err", 32'(errCode), 32'd0);
    tick(10);
    checkOutput("t4_to_err",  32'(errCode), 32'd3);
    checkOutput("t4_to_rdy",  32'(rxReady), 32'd0);
    checkOutput("t4_to_core", 32'(coreReset), 32'd1);
    checkOutput("t4_to_wrcnt", 32'(wrAddr.size()), 32'd1);
    if (wrAddr.size() == 1) checkOutput("t4_to_data0", wrData[0], 32'h2008_0005);

    $display("[TB] test 5: async reset mid-word");
    pulseRestart(1'b0);
    txQ = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    sendFrame(0);
    @(negedge clock);
    checkOutput("t5_pre_addr", imemAddr, 32'h4);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_we",   32'(imemWe),    32'd0);
    checkOutput("t5_rst_addr", imemAddr,       32'h0);
    checkOutput("t5_rst_data", imemWdata,      32'h0);
    checkOutput("t5_rst_core", 32'(coreReset), 32'd1);
    checkOutput("t5_rst_err",  32'(errCode),   32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    wrAddr.delete();
    wrData.delete();
    loadFrame1(8'h0E);
    sendFrame(0);
    checkFrame1Writes("t5");
    checkOutput("t5_done", 32'(done),      32'd1);
    checkOutput("t5_core", 32'(coreReset), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
